// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, bridge command encoding and bridge FSM states.
package uart_pkg;

  localparam logic [2:0] UART_CR_OFFSET   = 3'd0;
  localparam logic [2:0] UART_SR_OFFSET   = 3'd1;
  localparam logic [2:0] UART_DIN0_OFFSET = 3'd2;
  localparam logic [2:0] UART_DOUT0_OFFSET = 3'd4;

  localparam logic UART_CMD_WRITE = 1'b1;
  localparam logic UART_CMD_READ  = 1'b0;

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_REQ, RD_WAIT, RD_SEND} bridge_state_t;

  // Command byte layout for the default 3-bit address bus.
  typedef struct packed {
    logic [3:0] burst;
    logic [2:0] addr;
    logic       rw;
  } bridge_cmd_t;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Inter-byte timeout counter: cleared by load, pulses terminal count once after
// TIMEOUT_CYCLES unloaded clocks, then saturates until the next load.
module bridge_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_tc
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      cnt <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tc = !i_load && (cnt == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-level command decoder bridging UART RX/TX byte streams to the register bus,
// with burst auto-increment, inter-byte write timeout and RX overrun reporting.
module uart_reg_bridge #(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned EN_BURST       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [7:0]            o_reg_wdata,
  output logic                  o_reg_we,
  output logic                  o_reg_re,
  input  logic [7:0]            i_reg_rdata,
  input  logic                  i_reg_rvalid,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_overrun
);
  import uart_pkg::*;

  // Remaining bytes minus one, so the burst field loads directly.
  localparam int unsigned BW = 7 - ADDR_WIDTH;

  bridge_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BW-1:0]         rem;
  logic                  tmo_load;
  logic                  tmo_tc;
  logic                  in_read;

  assign tmo_load = (state != WR_DATA) || i_rx_valid;
  assign in_read  = (state == RD_REQ) || (state == RD_WAIT) || (state == RD_SEND);
  assign o_busy   = (state != IDLE);

  bridge_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(tmo_load),
    .o_tc  (tmo_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      addr        <= '0;
      rem         <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_reg_we    <= 1'b0;
      o_reg_re    <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_reg_we  <= 1'b0;
      o_reg_re  <= 1'b0;
      o_timeout <= 1'b0;
      o_overrun <= i_rx_valid && in_read;
      unique case (state)
        IDLE: begin
          if (i_rx_valid) begin
            addr  <= i_rx_data[ADDR_WIDTH:1];
            rem   <= (EN_BURST != 0) ? i_rx_data[7:ADDR_WIDTH+1] : '0;
            state <= (i_rx_data[0] == UART_CMD_WRITE) ? WR_DATA : RD_REQ;
          end
        end
        WR_DATA: begin
          if (i_rx_valid) begin
            o_reg_we    <= 1'b1;
            o_reg_wdata <= i_rx_data;
            o_reg_addr  <= addr;
            addr        <= addr + 1'b1;
            rem         <= rem - 1'b1;
            if (rem == '0) state <= IDLE;
          end else if (tmo_tc) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_REQ: begin
          o_reg_re   <= 1'b1;
          o_reg_addr <= addr;
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          if (i_reg_rvalid) begin
            o_tx_data  <= i_reg_rdata;
            o_tx_valid <= 1'b1;
            state      <= RD_SEND;
          end
        end
        RD_SEND: begin
          if (o_tx_valid && i_tx_ready) begin
            o_tx_valid <= 1'b0;
            addr       <= addr + 1'b1;
            rem        <= rem - 1'b1;
            state      <= (rem == '0) ? IDLE : RD_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench: stimulus pushes expected bus/TX/pulse events, a negedge monitor pops and compares.
module tb_uart_reg_bridge;

  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data  = '0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] rdata    = '0;
  logic       rvalid   = 1'b0;
  logic [7:0] tx_data, wdata;
  logic [2:0] reg_addr;
  logic       tx_valid, we, re, busy, tmo, ovr;

  logic [7:0] rx0_data  = '0;
  logic       rx0_valid = 1'b0;
  logic       tx0_ready = 1'b1;
  logic [7:0] rdata0    = '0;
  logic       rvalid0   = 1'b0;
  logic [7:0] tx0_data, wdata0;
  logic [2:0] reg_addr0;
  logic       tx0_valid, we0, re0, busy0, tmo0, ovr0;

  uart_reg_bridge #(.ADDR_WIDTH(3), .EN_BURST(1), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_reg_addr(reg_addr), .o_reg_wdata(wdata), .o_reg_we(we), .o_reg_re(re),
    .i_reg_rdata(rdata), .i_reg_rvalid(rvalid), .o_busy(busy), .o_timeout(tmo),
    .o_overrun(ovr)
  );

  uart_reg_bridge #(.ADDR_WIDTH(3), .EN_BURST(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx0_data), .i_rx_valid(rx0_valid),
    .o_tx_data(tx0_data), .o_tx_valid(tx0_valid), .i_tx_ready(tx0_ready),
    .o_reg_addr(reg_addr0), .o_reg_wdata(wdata0), .o_reg_we(we0), .o_reg_re(re0),
    .i_reg_rdata(rdata0), .i_reg_rvalid(rvalid0), .o_busy(busy0), .o_timeout(tmo0),
    .o_overrun(ovr0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  int wq[$];      // addr*256 + data
  int rq[$];      // read addresses
  int txq[$];     // bytes expected on TX
  int tq[$];      // cycle at which o_timeout is expected
  int w0q[$];     // writes expected from the EN_BURST=0 instance
  int dq[$];      // forced write data
  int forced[$];  // forced read data
  int ovr_exp = 0;
  int fix_lat = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b);
    rx0_data  = b;
    rx0_valid = 1'b1;
    tick();
    rx0_valid = 1'b0;
  endtask

  function automatic int blen(input logic [7:0] c);
    return int'(c[7:4]) + 1;
  endfunction

  task automatic do_write(input logic [7:0] cmd, input int nbytes, input int maxgap);
    int a;
    int d;
    a = int'(cmd[3:1]);
    send(cmd);
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      d = (dq.size() > 0) ? dq.pop_front() : int'($urandom_range(0, 255));
      wq.push_back(((a + i) % 8) * 256 + d);
      send(8'(d));
    end
  endtask

  task automatic do_read(input logic [7:0] cmd);
    int a;
    a = int'(cmd[3:1]);
    send(cmd);
    for (int i = 0; i < blen(cmd); i++) rq.push_back((a + i) % 8);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  // Register-file responder with arbitrary latency.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && re) begin
        int l;
        int d;
        l = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
        repeat (l) @(posedge clk);
        #1;
        d = (forced.size() > 0) ? forced.pop_front() : int'($urandom_range(0, 255));
        rdata  = 8'(d);
        rvalid = 1'b1;
        txq.push_back(d);
        tick();
        rvalid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      tick();
      tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (we || re) chk("we_re_exclusive", int'(we && re), 0);
        if (we) begin
          chk("write_expected", int'(wq.size() > 0), 1);
          if (wq.size() > 0) chk("write_addr_data", int'({reg_addr, wdata}), wq.pop_front());
        end
        if (re) begin
          chk("read_expected", int'(rq.size() > 0), 1);
          if (rq.size() > 0) chk("read_addr", int'(reg_addr), rq.pop_front());
        end
        if (prev_hold) chk("tx_held", int'({tx_valid, tx_data}), int'({1'b1, prev_data}));
        if (tx_valid && tx_ready) begin
          chk("tx_expected", int'(txq.size() > 0), 1);
          if (txq.size() > 0) chk("tx_byte", int'(tx_data), txq.pop_front());
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (tmo) begin
          chk("timeout_expected", int'(tq.size() > 0), 1);
          if (tq.size() > 0) chk("timeout_cycle", cyc, tq.pop_front());
        end
        if (ovr) begin
          chk("overrun_expected", int'(ovr_exp > 0), 1);
          if (ovr_exp > 0) ovr_exp--;
        end
        if (we0) begin
          chk("nb_write_expected", int'(w0q.size() > 0), 1);
          if (w0q.size() > 0) chk("nb_write_addr_data", int'({reg_addr0, wdata0}), w0q.pop_front());
        end
        if (re0 || tmo0 || ovr0 || tx0_valid) chk("nb_spurious", int'({re0, tmo0, ovr0, tx0_valid}), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_outputs", int'({tx_data, tx_valid, reg_addr, wdata, we, re, tmo, ovr}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("nb_reset_outputs", int'({tx0_data, tx0_valid, reg_addr0, wdata0, we0, re0, busy0}), 0);
    rst = 1'b0;
    tick();

    // Single write.
    dq.push_back(8'hA5);
    do_write(8'h07, 1, 0);
    tick();
    chk("t1_busy_after", int'(busy), 0);

    // Burst read, latency 2, tx_ready toggling.
    forced.push_back(8'h11);
    forced.push_back(8'h22);
    forced.push_back(8'h33);
    fix_lat = 2;
    do_read(8'h22);
    wait_idle("t2_idle");
    fix_lat = 0;

    // Address wrap.
    dq.push_back(1);
    dq.push_back(2);
    dq.push_back(3);
    do_write(8'h2F, 3, 2);

    // Timeout after one of two data bytes.
    do_write(8'h13, 1, 0);
    tq.push_back(cyc + TMO);
    repeat (TMO + 5) tick();
    chk("t4_timeout_seen", tq.size(), 0);
    chk("t4_idle", int'(busy), 0);
    dq.push_back(8'h5A);
    do_write(8'h05, 1, 0);

    // Overrun during RD_WAIT.
    fix_lat = 6;
    do_read(8'h08);
    ovr_exp++;
    tick();
    send(8'hFF);
    wait_idle("t5_idle");
    fix_lat = 0;
    chk("t5_overrun_seen", ovr_exp, 0);

    // Reset mid-burst.
    do_write(8'h61, 2, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_reset_outputs", int'({tx_data, tx_valid, reg_addr, wdata, we, re, tmo, ovr}), 0);
    chk("t6_reset_busy", int'(busy), 0);
    dq.push_back(8'h77);
    do_write(8'h0B, 1, 0);

    // EN_BURST=0: burst field ignored.
    send0(8'hF7);
    w0q.push_back(3 * 256 + 8'hAB);
    send0(8'hAB);
    chk("t6b_idle_after_single", int'(busy0), 0);
    send0(8'hCD);
    w0q.push_back(6 * 256 + 8'h11);
    send0(8'h11);
    chk("t6b_idle_after_second", int'(busy0), 0);

    // Random command mix.
    repeat (40) begin
      logic [7:0] cmd;
      cmd = 8'($urandom_range(0, 255));
      if (cmd[0]) do_write(cmd, blen(cmd), 3);
      else do_read(cmd);
      wait_idle("rand_idle");
    end

    repeat (5) tick();
    chk("writes_drained", wq.size(), 0);
    chk("reads_drained", rq.size(), 0);
    chk("tx_drained", txq.size(), 0);
    chk("timeouts_drained", tq.size(), 0);
    chk("overruns_drained", ovr_exp, 0);
    chk("nb_writes_drained", w0q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
